// File: rtl/aes_inv_cipher_pkg.sv
// Shared definitions for the AES-128 inverse cipher: round count,
// FSM state encoding and the GF(2^8) reduction constant.
package aes_inv_cipher_pkg;

   localparam int NUM_ROUNDS = 10;

   // Low byte of the AES polynomial x^8 + x^4 + x^3 + x + 1 (0x11B)
   localparam logic [7:0] GF_POLY = 8'h1B;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      FINAL = 2'd2
   } fsm_t;

   // Multiply by x in GF(2^8)
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/aes_inv_cipher_inv_sub_bytes.sv
// InvSubBytes on a full 128-bit AES state: 16 parallel inverse S-box lookups.
// Ports: din (state in), dout (state with every byte replaced), purely combinational.
module aes_inv_cipher_inv_sub_bytes (
   input  logic [127:0] din,
   output logic [127:0] dout
);

   // Entry 0 sits in the top byte, entry 255 in the bottom byte
   localparam logic [2047:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   for (genvar i = 0; i < 16; i++) begin : g_byte
      assign dout[127-8*i -: 8] =
         INV_SBOX[2047 - 8*int'(din[127-8*i -: 8]) -: 8];
   end

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 inverse cipher, one round per clock, 11 cycles per block.
// Ports: clk, rst (sync, active-high), start/inp_data (request + ciphertext),
// key_round/key_data (external round-key table), busy, done, out_data (plaintext).
module aes_inv_cipher
   import aes_inv_cipher_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] inp_data,
   output logic [3:0]   key_round,
   input  logic [127:0] key_data,
   output logic         busy,
   output logic         done,
   output logic [127:0] out_data
);

   localparam logic [3:0] KR_LAST = 4'(NUM_ROUNDS);

   fsm_t st, st_nx;
   logic [127:0] state_q;
   logic [3:0]   kr_q;
   logic         done_q;
   logic [127:0] out_q;

   logic [127:0] isr, isb, ark, round_out;

   // Byte i of the state is row i%4, column i/4
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(r+4*((c+r)%4)) -: 8] = s[127-8*(r+4*c) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [7:0] a [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      logic [7:0] x2, x4, x8;
      logic [31:0] o;
      for (int r = 0; r < 4; r++) begin
         a[r]  = col[31-8*r -: 8];
         x2    = xtime(a[r]);
         x4    = xtime(x2);
         x8    = xtime(x4);
         m9[r] = x8 ^ a[r];
         mb[r] = x8 ^ x2 ^ a[r];
         md[r] = x8 ^ x4 ^ a[r];
         me[r] = x8 ^ x4 ^ x2;
      end
      o = '0;
      for (int r = 0; r < 4; r++) begin
         o[31-8*r -: 8] = me[r] ^ mb[(r+1)%4]
                        ^ md[(r+2)%4] ^ m9[(r+3)%4];
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
      end
      return o;
   endfunction

   assign isr = inv_shift_rows(state_q);

   aes_inv_cipher_inv_sub_bytes u_isb (
      .din  (isr),
      .dout (isb)
   );

   // ark doubles as the FINAL result, which skips InvMixColumns
   assign ark       = isb ^ key_data;
   assign round_out = inv_mix_columns(ark);

   always_ff @(posedge clk) begin
      if (rst) st <= IDLE;
      else     st <= st_nx;
   end

   always_comb begin
      st_nx = st;
      unique case (st)
         IDLE:    if (start) st_nx = ROUND;
         ROUND:   if (kr_q == 4'd1) st_nx = FINAL;
         FINAL:   st_nx = IDLE;
         default: st_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= '0;
         kr_q    <= KR_LAST;
         done_q  <= 1'b0;
         out_q   <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (st)
            IDLE: begin
               if (start) begin
                  state_q <= inp_data ^ key_data;
                  kr_q    <= KR_LAST - 4'd1;
               end
            end
            ROUND: begin
               state_q <= round_out;
               kr_q    <= kr_q - 4'd1;
            end
            FINAL: begin
               out_q  <= ark;
               kr_q   <= KR_LAST;
               done_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign key_round = kr_q;
   assign busy      = (st != IDLE);
   assign done      = done_q;
   assign out_data  = out_q;

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Self-checking bench for aes_inv_cipher: FIPS-197 vectors, corner sequences
// and random blocks against a GF(2^8)-arithmetic reference model.
module tb_aes_inv_cipher;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [127:0] inp_data;
   logic [3:0]   key_round;
   logic [127:0] key_data;
   logic         busy;
   logic         done;
   logic [127:0] out_data;

   int checks = 0;
   int errors = 0;

   logic [7:0]   sbox [256];
   logic [7:0]   isbox [256];
   logic [127:0] rk [16];
   logic [127:0] prev_out;

   typedef struct {
      logic [127:0] key;
      logic [127:0] ct;
      logic [127:0] pt;
   } vec_t;

   vec_t vecs [2];

   always #5 clk = ~clk;

   assign key_data = rk[key_round];

   aes_inv_cipher dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .inp_data  (inp_data),
      .key_round (key_round),
      .key_data  (key_data),
      .busy      (busy),
      .done      (done),
      .out_data  (out_data)
   );

   task automatic check(input string name, input logic [127:0] act,
                        input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                         input logic [7:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   // S-box from its definition: multiplicative inverse then affine map
   task automatic build_sbox();
      logic [7:0] inv, b;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         b = inv;
         sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
                 ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
      end
      for (int x = 0; x < 256; x++) isbox[sbox[x]] = 8'(x);
   endtask

   task automatic expand_key(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rcon;
      rcon = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox[t[31:24]], sbox[t[23:16]],
                 sbox[t[15:8]], sbox[t[7:0]]};
            t[31:24] = t[31:24] ^ rcon;
            rcon = gf_mul(rcon, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++)
         rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      for (int r = 11; r < 16; r++) rk[r] = '0;
   endtask

   function automatic logic [127:0] model_decrypt(input logic [127:0] ct);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [127:0] o;
      for (int i = 0; i < 16; i++)
         s[i] = ct[127-8*i -: 8] ^ rk[10][127-8*i -: 8];
      for (int rnd = 9; rnd >= 0; rnd--) begin
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               t[r+4*((c+r)%4)] = isbox[s[r+4*c]];
         for (int i = 0; i < 16; i++)
            t[i] = t[i] ^ rk[rnd][127-8*i -: 8];
         if (rnd > 0) begin
            for (int c = 0; c < 4; c++)
               for (int r = 0; r < 4; r++)
                  s[4*c+r] = gf_mul(8'h0e, t[4*c+r])
                           ^ gf_mul(8'h0b, t[4*c+(r+1)%4])
                           ^ gf_mul(8'h0d, t[4*c+(r+2)%4])
                           ^ gf_mul(8'h09, t[4*c+(r+3)%4]);
         end else begin
            s = t;
         end
      end
      o = '0;
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
      return o;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Caller places time either at a negedge or #1 after the edge that
   // raised done; returns #1 after the edge that raises done.
   task automatic run_block(input logic [127:0] key,
                            input logic [127:0] ct,
                            input logic [127:0] exp,
                            input bit glitch,
                            input bit trace);
      logic [3:0] exp_kr;
      expand_key(key);
      check("hold_out", out_data, prev_out);
      check("start_kr", key_round, 4'd10);
      check("start_busy", busy, 1'b0);
      start    = 1'b1;
      inp_data = ct;
      for (int k = 0; k <= 10; k++) begin
         @(posedge clk);
         #1;
         start    = 1'b0;
         inp_data = rand128();
         exp_kr   = (k <= 9) ? 4'(9 - k) : 4'd10;
         if (trace) check($sformatf("kr_k%0d", k), key_round, exp_kr);
         check($sformatf("done_k%0d", k), done, k == 10);
         check($sformatf("busy_k%0d", k), busy, k <= 9);
         if (glitch && (k + 1 == 3 || k + 1 == 7)) start = 1'b1;
      end
      check("result", out_data, exp);
      prev_out = exp;
   endtask

   task automatic expect_done_low();
      @(posedge clk);
      #1;
      check("done_fall", done, 1'b0);
   endtask

   initial begin
      logic [127:0] k, c;
      int seen;

      vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                  128'h00112233445566778899aabbccddeeff};
      vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                  128'h3925841d02dc09fbdc118597196a0b32,
                  128'h3243f6a8885a308d313198a2e0370734};

      for (int i = 0; i < 16; i++) rk[i] = '0;
      build_sbox();
      prev_out = '0;

      // Reset with start held high: reset must win
      rst      = 1'b1;
      start    = 1'b1;
      inp_data = rand128();
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_kr", key_round, 4'd10);
      check("rst_out", out_data, 128'h0);
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_idle", busy, 1'b0);

      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         run_block(vecs[i].key, vecs[i].ct, vecs[i].pt, 1'b0, 1'b1);
         expect_done_low();
      end

      // Start pulses while busy, then back-to-back start in done cycle
      @(negedge clk);
      run_block(vecs[0].key, vecs[0].ct, vecs[0].pt, 1'b1, 1'b1);
      run_block(vecs[1].key, vecs[1].ct, vecs[1].pt, 1'b0, 1'b1);
      expect_done_low();

      // Abort with reset at the fifth edge after start
      @(negedge clk);
      expand_key(vecs[0].key);
      start    = 1'b1;
      inp_data = vecs[0].ct;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_kr", key_round, 4'd10);
      check("abort_out", out_data, 128'h0);
      prev_out = '0;
      @(negedge clk);
      rst  = 1'b0;
      seen = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (done) seen++;
      end
      check("abort_no_done", seen, 0);
      @(negedge clk);
      run_block(vecs[0].key, vecs[0].ct, vecs[0].pt, 1'b0, 1'b1);
      expect_done_low();

      // Random keys and ciphertexts against the reference model
      for (int i = 0; i < 6; i++) begin
         k = rand128();
         c = rand128();
         expand_key(k);
         @(negedge clk);
         run_block(k, c, model_decrypt(c), 1'b0, 1'b0);
         if (i % 2 == 0) expect_done_low();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/aes_inv_cipher.md
AES_INV_CIPHER -- requirements
Module: aes_inv_cipher

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: rst  in  1  reset, synchronous and active-high.
REQ-003 SHALL have port: start  in  1  request to decrypt inp_data; sampled only in IDLE.
REQ-004 SHALL have port: inp_data  in  128  ciphertext block, byte 0 in bits [127:120], column-major AES state order.
REQ-005 SHALL have port: key_round  out  4  registered round-key index presented to the external round-key table.
REQ-006 SHALL have port: key_data  in  128  round key selected by key_round; combinational table read, valid in the same cycle.
REQ-007 SHALL have port: busy  out  1  high in ROUND and FINAL.
REQ-008 SHALL have port: done  out  1  one-cycle pulse; out_data is valid.
REQ-009 SHALL have port: out_data  out  128  plaintext block, registered, held until the next done.

Function
REQ-010 SHALL implement FSM states IDLE, ROUND, FINAL, with a 128-bit state register and a 4-bit key_round register.
REQ-011 In IDLE, key_round SHALL equal 10.
REQ-012 On the IDLE cycle with start=1, SHALL load state <= inp_data ^ key_data (rk10), set key_round <= 9, and go to ROUND.
REQ-013 Each ROUND cycle SHALL compute state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ key_data) and decrement key_round.
REQ-014 SHALL leave ROUND for FINAL on the cycle where key_round=1, so that FINAL sees key_round=0.
REQ-015 In FINAL, SHALL compute out_data <= InvSubBytes(InvShiftRows(state)) ^ key_data, with no InvMixColumns.
REQ-016 FINAL SHALL also set key_round <= 10 and go to IDLE.
REQ-017 done SHALL be asserted for exactly the one cycle after the FINAL edge.
REQ-018 Latency: start sampled at edge N -> done high during cycle N+11. Throughput is one block per 11 cycles.
REQ-019 InvShiftRows SHALL rotate row r right by r bytes, r = 0..3.
REQ-020 InvMixColumns SHALL use matrix {0e,0b,0d,09} over GF(2^8), polynomial 0x11B, built from an xtime chain.
REQ-021 start while busy=1 SHALL be ignored, with no effect on the current block or on out_data.
REQ-022 start in the cycle done is high (FSM already in IDLE) SHALL be accepted normally; out_data SHALL hold the previous result until the new done.
REQ-023 inp_data SHALL be sampled only on the accepting edge; later changes SHALL NOT affect the result.

Reset
REQ-024 On rst=1 at a clock edge, SHALL force: state IDLE, key_round=10, busy=0, done=0, out_data=0, state register=0.
REQ-025 rst asserted mid-operation SHALL abort the block with no done pulse; start is honoured from the first edge after rst deasserts.
REQ-026 rst SHALL take priority over start.

Structure
REQ-027 A shared package SHALL hold: NUM_ROUNDS=10, the FSM state encoding, and the GF(2^8) reduction constant 8'h1B.
REQ-028 The inverse S-box SHALL be a sub-module INV_SUB_BYTES: 128-bit combinational, 16 parallel 256-entry lookups, reusable by other decryption-path blocks.
REQ-029 InvShiftRows, InvMixColumns and AddRoundKey SHALL be local combinational logic; no other sub-modules.

Verification
REQ-030 FIPS-197 App. C.1: key table from key 000102030405060708090a0b0c0d0e0f, start with 69c4e0d86a7b0430d8cdb78070b4c55a -> done at N+11, out_data=00112233445566778899aabbccddeeff.
REQ-031 FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, input 3925841d02dc09fbdc118597196a0b32 -> out_data=3243f6a8885a308d313198a2e0370734.
REQ-032 key_round trace after start SHALL read 10,9,8,...,1,0,10; key_round=10 (rk10=13111d7fe3944a17f307a78b4d2b30c5 for C.1) SHALL be presented in the start cycle.
REQ-033 Start pulsed at N+3 and N+7 during a C.1 block -> single done at N+11, result unchanged; back-to-back start in the done cycle -> second done exactly 11 cycles later.
REQ-034 rst at N+5 -> done never pulses for that block, out_data=0, busy=0, key_round=10 next cycle; a new C.1 block then completes correctly.
